// File: rtl/bk_add_sched.sv
// Two-requester 32-bit adder scheduler: a single 16-bit Brent-Kung adder is
// time-shared across low, high and carry-propagate passes for each operation.

module bk_add16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [16:0] s_o
);

    // Brent-Kung prefix tree: up-sweep builds power-of-two group carries,
    // down-sweep fills in the remaining prefixes.
    function automatic logic [16:0] bk_sum(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] p;
        logic [15:0] gg;
        logic [15:0] pp;
        logic [16:0] s;
        int          i;
        p  = a ^ b;
        gg = a & b;
        pp = p;
        for (int lv = 0; lv < 4; lv++) begin
            for (int k = 0; k < (8 >> lv); k++) begin
                i      = (k << (lv + 1)) + (2 << lv) - 1;
                gg[i]  = gg[i] | (pp[i] & gg[i - (1 << lv)]);
                pp[i]  = pp[i] & pp[i - (1 << lv)];
            end
        end
        for (int lv = 2; lv >= 0; lv--) begin
            for (int k = 0; k < (8 >> lv) - 1; k++) begin
                i      = (3 << lv) - 1 + (k << (lv + 1));
                gg[i]  = gg[i] | (pp[i] & gg[i - (1 << lv)]);
                pp[i]  = pp[i] & pp[i - (1 << lv)];
            end
        end
        s[0] = p[0];
        for (int j = 1; j < 16; j++) begin
            s[j] = p[j] ^ gg[j - 1];
        end
        s[16] = gg[15];
        return s;
    endfunction

    assign s_o = bk_sum(a_i, b_i);

endmodule

module bk_add_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [32:0] rsp_sum,
    output logic [15:0] op_cnt,
    output logic [15:0] inc_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        INC  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        id_q, id_d;
    logic [15:0] lo_q, lo_d;
    logic [16:0] hi_q, hi_d;
    logic        c_q, c_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] op_cnt_q, op_cnt_d;
    logic [15:0] inc_cnt_q, inc_cnt_d;

    logic        grant_s;
    logic [15:0] add_a_s;
    logic [15:0] add_b_s;
    logic [16:0] add_sum_s;

    bk_add16 u_add (
        .a_i (add_a_s),
        .b_i (add_b_s),
        .s_o (add_sum_s)
    );

    // Round-robin arbitration; readys only ever asserted while idle.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_q;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        req0_ready = (state_q == IDLE) && req0_valid && !grant_s;
        req1_ready = (state_q == IDLE) && req1_valid && grant_s;
    end

    // Adder operand selection per pass.
    always_comb begin
        add_a_s = 16'h0000;
        add_b_s = 16'h0000;
        case (state_q)
            LO: begin
                add_a_s = a_q[15:0];
                add_b_s = b_q[15:0];
            end
            HI: begin
                add_a_s = a_q[31:16];
                add_b_s = b_q[31:16];
            end
            INC: begin
                add_a_s = hi_q[15:0];
                add_b_s = 16'h0001;
            end
            default: begin
                add_a_s = 16'h0000;
                add_b_s = 16'h0000;
            end
        endcase
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        c_d          = c_q;
        rsp_valid_d  = rsp_valid_q;
        op_cnt_d     = op_cnt_q;
        inc_cnt_d    = inc_cnt_q;
        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    a_d          = grant_s ? req1_a : req0_a;
                    b_d          = grant_s ? req1_b : req0_b;
                    id_d         = grant_s;
                    last_grant_d = grant_s;
                    state_d      = LO;
                end else begin
                    state_d = IDLE;
                end
            end
            LO: begin
                lo_d    = add_sum_s[15:0];
                c_d     = add_sum_s[16];
                state_d = HI;
            end
            HI: begin
                hi_d = add_sum_s;
                if (c_q) begin
                    state_d = INC;
                end else begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                end
            end
            INC: begin
                hi_d        = {hi_q[16] | add_sum_s[16], add_sum_s[15:0]};
                inc_cnt_d   = (inc_cnt_q == 16'hFFFF) ? inc_cnt_q : inc_cnt_q + 16'd1;
                state_d     = DONE;
                rsp_valid_d = 1'b1;
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_cnt_d    = (op_cnt_q == 16'hFFFF) ? op_cnt_q : op_cnt_q + 16'd1;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= 32'h0000_0000;
            b_q          <= 32'h0000_0000;
            id_q         <= 1'b0;
            lo_q         <= 16'h0000;
            hi_q         <= 17'h0_0000;
            c_q          <= 1'b0;
            rsp_valid_q  <= 1'b0;
            op_cnt_q     <= 16'h0000;
            inc_cnt_q    <= 16'h0000;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            c_q          <= c_d;
            rsp_valid_q  <= rsp_valid_d;
            op_cnt_q     <= op_cnt_d;
            inc_cnt_q    <= inc_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_sum   = {hi_q, lo_q};
    assign op_cnt    = op_cnt_q;
    assign inc_cnt   = inc_cnt_q;

endmodule

// File: tb/tb_bk_add_sched.sv
// Bench for bk_add_sched: directed scenarios plus random traffic, checked
// every cycle against a transaction-level reference model.

module tb_bk_add_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id;
    logic [32:0] rsp_sum;
    logic [15:0] op_cnt, inc_cnt;

    bk_add_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .op_cnt     (op_cnt),
        .inc_cnt    (inc_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: one pending transaction with its cycles-to-visible.
    bit          m_have;
    int          m_wait;
    int          m_lat;
    logic [32:0] m_sum;
    logic        m_id;
    logic        m_last;
    int          m_op;
    int          m_inc;
    bit          e_r0, e_r1;
    logic        grants[$];
    logic [32:0] seen_sum = 33'h0;
    logic        seen_id  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_have = 1'b0;
        m_wait = 0;
        m_lat  = 0;
        m_last = 1'b1;
        m_op   = 0;
        m_inc  = 0;
    endtask

    // One clock cycle: check mid-cycle, advance the model on the edge.
    task automatic cycle();
        logic [31:0] a, b;
        @(negedge clk);
        e_r0 = !m_have && req0_valid && (!req1_valid || m_last);
        e_r1 = !m_have && req1_valid && (!req0_valid || !m_last);
        chk("req0_ready", 64'(req0_ready), 64'(e_r0));
        chk("req1_ready", 64'(req1_ready), 64'(e_r1));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_have && m_wait == 0));
        if (m_have && m_wait == 0) begin
            chk("rsp_sum", 64'(rsp_sum), 64'(m_sum));
            chk("rsp_id", 64'(rsp_id), 64'(m_id));
            seen_sum = rsp_sum;
            seen_id  = rsp_id;
        end
        chk("op_cnt", 64'(op_cnt), 64'(m_op));
        chk("inc_cnt", 64'(inc_cnt), 64'(m_inc));
        @(posedge clk);
        if (m_have) begin
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0 && m_lat == 3 && m_inc < 65535) m_inc++;
            end else if (rsp_ready) begin
                m_have = 1'b0;
                if (m_op < 65535) m_op++;
            end
        end else if (e_r0 || e_r1) begin
            a      = e_r1 ? req1_a : req0_a;
            b      = e_r1 ? req1_b : req0_b;
            m_sum  = {1'b0, a} + {1'b0, b};
            m_lat  = ((32'(a[15:0]) + 32'(b[15:0])) > 32'h0000_FFFF) ? 3 : 2;
            m_wait = m_lat;
            m_id   = e_r1;
            m_last = e_r1;
            m_have = 1'b1;
            grants.push_back(e_r1);
        end
        #1;
    endtask

    task automatic do_reset(input string tag);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_sum"}, 64'(rsp_sum), 64'd0);
        chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
        chk({tag, "_op_cnt"}, 64'(op_cnt), 64'd0);
        chk({tag, "_inc_cnt"}, 64'(inc_cnt), 64'd0);
        chk({tag, "_ready"}, 64'({req0_ready, req1_ready}), 64'd0);
        model_reset();
        grants.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_op(input int kind);
        logic [31:0] r;
        r = $urandom;
        case (kind)
            1:       return {r[31:16], 16'hFFFF};
            2:       return 32'hFFFF_FFFF;
            3:       return {16'hFFFF, r[15:0]};
            default: return r;
        endcase
    endfunction

    task automatic drive_rand();
        req0_valid = ($urandom_range(0, 1) == 1);
        req1_valid = ($urandom_range(0, 1) == 1);
        rsp_ready  = ($urandom_range(0, 9) < 7);
        req0_a     = rand_op($urandom_range(0, 4));
        req0_b     = rand_op($urandom_range(0, 4));
        req1_a     = rand_op($urandom_range(0, 4));
        req1_b     = rand_op($urandom_range(0, 4));
    endtask

    task automatic one_op(input logic id, input logic [31:0] a, input logic [31:0] b);
        req0_valid = !id;
        req1_valid = id;
        req0_a     = a;
        req0_b     = b;
        req1_a     = a;
        req1_b     = b;
        rsp_ready  = 1'b1;
        cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (6) cycle();
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        req0_a     = 32'h0;
        req0_b     = 32'h0;
        req1_a     = 32'h0;
        req1_b     = 32'h0;
        model_reset();
        do_reset("por");

        // Basic operations, no-carry then carry-propagate cases.
        one_op(1'b0, 32'h1234_5678, 32'h1111_1111);
        chk("d031_sum", 64'(seen_sum), 64'h0_2345_6789);
        chk("d031_id", 64'(seen_id), 64'd0);
        chk("d031_cnts", 64'({op_cnt, inc_cnt}), 64'h0001_0000);
        one_op(1'b1, 32'h0000_FFFF, 32'h0000_0001);
        chk("d032_sum", 64'(seen_sum), 64'h0_0001_0000);
        chk("d032_id", 64'(seen_id), 64'd1);
        chk("d032_cnts", 64'({op_cnt, inc_cnt}), 64'h0002_0001);
        one_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        chk("d033_sum", 64'(seen_sum), 64'h1_0000_0000);
        chk("d033_cnts", 64'({op_cnt, inc_cnt}), 64'h0003_0002);

        // Continuous contention from reset alternates grants.
        do_reset("d034");
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 24; i++) begin
            req0_a = rand_op($urandom_range(0, 4));
            req0_b = rand_op($urandom_range(0, 4));
            req1_a = rand_op($urandom_range(0, 4));
            req1_b = rand_op($urandom_range(0, 4));
            cycle();
        end
        chk("d034_ngrants", 64'(grants.size() >= 4), 64'd1);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            chk("d034_grant", 64'(grants[i]), 64'(i % 2));
        end

        // Consumer back-pressure: response held stable, no new accepts.
        rsp_ready = 1'b0;
        repeat (10) cycle();
        rsp_ready = 1'b1;
        repeat (4) cycle();

        // Reset while in the high pass aborts the operation.
        do_reset("d036a");
        req0_valid = 1'b1;
        req0_a     = 32'h8000_FFFF;
        req0_b     = 32'h8000_0001;
        rsp_ready  = 1'b1;
        cycle();
        req0_valid = 1'b0;
        cycle();
        do_reset("d036b");
        repeat (6) cycle();
        one_op(1'b1, 32'hDEAD_BEEF, 32'h2152_4111);
        chk("d036_sum", 64'(seen_sum), 64'h1_0000_0000);
        chk("d036_cnts", 64'({op_cnt, inc_cnt}), 64'h0001_0001);

        // Random traffic with valid withdrawal and back-pressure.
        for (int i = 0; i < 800; i++) begin
            drive_rand();
            cycle();
        end
        chk("rand_ops_done", 64'(m_op > 20), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
